audio_recorder: RTL and testbench
=================================

# audio_recorder

Front-end capture stage that sits directly upstream of `receive`. It gates the microphone sample stream with the record button and decimates it by boxcar averaging, from the mic rate (96 kHz) down to the 12 kHz, 8-bit stream that `receive` consumes. It caps each take at a fixed length and signals the end of every take with a single-cycle `record_done` pulse.

## Interface
- `DECIM`, default 8: decimation ratio (mic samples per output sample); power of two, ≥2.
- `MAX_SAMPLES`, default 24000: maximum output samples per take (2 s at 12 kHz).
- `clk_in`  input  1  system clock; the only clock.
- `rst_in`  input  1  synchronous, active-high reset.
- `record_in`  input  1  debounced record button, level; high = record.
- `mic_in`  input  8  signed two's-complement mic sample.
- `mic_valid_in`  input  1  one-cycle strobe qualifying `mic_in`.
- `audio_out`  output  8  signed decimated sample; feeds `receive.audio_in`.
- `audio_valid_out`  output  1  one-cycle strobe qualifying `audio_out`.
- `record_done_out`  output  1  one-cycle pulse at end of take; feeds `receive.record_done`.
- `recording_out`  output  1  high while in RECORD; drives the LED.

## Operation
- States: IDLE, RECORD, DONE.
- IDLE → RECORD:
  - On a rising edge of `record_in`, detected from a registered copy of the previous value.
  - A level that is already high at reset release does not start a take. The button must be released and pressed again.
  - On entry, the accumulator, phase counter and sample counter are cleared.
- RECORD, accumulation:
  - Each `mic_valid_in` adds the sign-extended `mic_in` to the accumulator. Accumulator width is 8+log2(DECIM).
  - The phase counter counts 0..DECIM-1.
- RECORD, sample emission:
  - On the DECIM-th valid, `audio_out` is set to the sum including that sample, arithmetic-shifted right by log2(DECIM). This is truncation toward −∞.
  - `audio_valid_out` pulses. The accumulator restarts from 0 and the sample counter increments.
- RECORD → DONE occurs when either:
  - `record_in` is low, or
  - the sample counter equals MAX_SAMPLES after an increment.
- Partial accumulation at stop: discarded, never emitted.
- Simultaneous stop and sample completion:
  - If `record_in` falls in the same cycle that completes a sample, that sample is emitted.
  - The take then ends.
- DONE:
  - One cycle. `record_done_out` = 1.
  - Then → IDLE unconditionally.
- `mic_valid_in` outside RECORD is ignored.
- `recording_out` = 1 exactly while state is RECORD.

## Timing
- Reset values: `audio_out` = 0, `audio_valid_out` = 0, `record_done_out` = 0, `recording_out` = 0, state IDLE.
- Outputs are registered. `audio_valid_out` asserts the cycle after the clock edge that samples the DECIM-th `mic_valid_in`.
- `audio_out` holds its value until the next emission.
- `record_done_out`:
  - Asserts the cycle after the stop condition is sampled.
  - Is never coincident with `audio_valid_out`. It follows the last valid by ≥1 cycle.
  - Pulses exactly once per take.
- Back-to-back `mic_valid_in` on every cycle is supported; there is no backpressure.
- Reset mid-take: the state machine returns to IDLE on the next edge and `record_done_out` does not pulse.
- A take with zero emitted samples (release before DECIM valids) still produces one `record_done_out` pulse.
- Sample counter width is $clog2(MAX_SAMPLES+1); it never wraps.

## Structure
- Shared package `audio_pkg` holds:
  - `SAMPLE_W` = 8, `MIC_RATE_HZ`, `AUDIO_RATE_HZ` = 12000;
  - the `rec_state_t` enum {IDLE, RECORD, DONE}.
- Sub-module `boxcar_decimator` (parameter DECIM):
  - inputs: clear, sample, valid;
  - outputs: averaged sample, valid;
  - contains the accumulator, the phase counter and the shift.
- The top level holds the FSM, edge detect, sample counter and done pulse.

## Test plan
- Press `record_in`, then 16 valids of `mic_in` = 10 with DECIM=8 → two `audio_valid_out` pulses with `audio_out` = 10. Release → `record_done_out` pulses once, with no partial sample.
- Eight valids alternating −128 and 127 → `audio_out` = −1 (sum −4 >>> 3). Eight valids of −1 → `audio_out` = −1.
- MAX_SAMPLES=3, continuous valids with `record_in` held high:
  - exactly 3 `audio_valid_out` pulses;
  - `record_done_out` one cycle after the 3rd;
  - no restart until `record_in` drops and rises again.
- `record_in` falls in the same cycle as the 8th valid → that sample is emitted, then `record_done_out` the next cycle.
- Assert `rst_in` after 5 valids mid-take:
  - all outputs are 0 next cycle;
  - `record_done_out` never pulses;
  - a new press restarts with a clean accumulator.
- `record_in` high through reset release → no take starts until a fresh rising edge; `mic_valid_in` in IDLE produces no output.

Source files
------------

// File: rtl/audio_recorder_pkg.sv
// audio_pkg: shared constants and FSM state type for the audio capture front end.
package audio_pkg;
    localparam int SAMPLE_W = 8;
    localparam int MIC_RATE_HZ = 96000;
    localparam int AUDIO_RATE_HZ = 12000;
    typedef enum logic [1:0] {IDLE, RECORD, DONE} rec_state_t;
endpackage

// File: rtl/audio_recorder_if.sv
// audio_recorder_if: record button, mic sample stream and decimated audio stream.
interface audio_recorder_if;
    import audio_pkg::*;
    logic                record_in;
    logic [SAMPLE_W-1:0] mic_in;
    logic                mic_valid_in;
    logic [SAMPLE_W-1:0] audio_out;
    logic                audio_valid_out;
    logic                record_done_out;
    logic                recording_out;
    modport master (
        output record_in, mic_in, mic_valid_in,
        input  audio_out, audio_valid_out, record_done_out, recording_out
    );
    modport slave (
        input  record_in, mic_in, mic_valid_in,
        output audio_out, audio_valid_out, record_done_out, recording_out
    );
endinterface

// File: rtl/audio_recorder_decim.sv
// boxcar_decimator: sums DECIM signed samples and emits the floor average.
// fire_o flags the valid that completes a sample, so the caller can act on the same edge.
module boxcar_decimator
    import audio_pkg::*;
#(
    parameter int DECIM = 8
) (
    input  logic                clk_in,
    input  logic                rst_in,
    input  logic                clear_i,
    input  logic [SAMPLE_W-1:0] sample_i,
    input  logic                valid_i,
    output logic [SAMPLE_W-1:0] avg_o,
    output logic                avg_valid_o,
    output logic                fire_o
);
    localparam int SH = $clog2(DECIM);
    localparam int AW = SAMPLE_W + SH;

    logic [AW-1:0]       acc_q, acc_d, sum;
    logic [SH-1:0]       phase_q, phase_d;
    logic [SAMPLE_W-1:0] avg_q, avg_d;
    logic                avg_valid_q;

    // The top SAMPLE_W bits of the sum are the arithmetic right shift by SH.
    always_comb begin
        sum     = acc_q + {{SH{sample_i[SAMPLE_W-1]}}, sample_i};
        fire_o  = valid_i && phase_q == SH'(DECIM - 1);
        acc_d   = (clear_i || fire_o) ? '0 : valid_i ? sum : acc_q;
        phase_d = (clear_i || fire_o) ? '0 : valid_i ? phase_q + 1'b1 : phase_q;
        avg_d   = fire_o ? sum[AW-1:SH] : avg_q;
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            acc_q       <= '0;
            phase_q     <= '0;
            avg_q       <= '0;
            avg_valid_q <= 1'b0;
        end else begin
            acc_q       <= acc_d;
            phase_q     <= phase_d;
            avg_q       <= avg_d;
            avg_valid_q <= fire_o;
        end
    end

    assign avg_o       = avg_q;
    assign avg_valid_o = avg_valid_q;
endmodule

// File: rtl/audio_recorder.sv
// audio_recorder: record-button gated capture, boxcar decimation and take length control.
module audio_recorder
    import audio_pkg::*;
#(
    parameter int DECIM       = MIC_RATE_HZ / AUDIO_RATE_HZ,
    parameter int MAX_SAMPLES = 24000
) (
    input logic              clk_in,
    input logic              rst_in,
    audio_recorder_if.slave  bus
);
    localparam int CW = $clog2(MAX_SAMPLES + 1);

    rec_state_t    state_q, state_d;
    logic          rec_q;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          start, fire, dec_valid;

    assign start     = state_q == IDLE && bus.record_in && !rec_q;
    assign dec_valid = bus.mic_valid_in && state_q == RECORD;
    assign cnt_d     = start ? '0 : fire ? cnt_q + 1'b1 : cnt_q;

    // rec_q resets high so a button already held at reset release is not a press.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q <= IDLE;
            rec_q   <= 1'b1;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            rec_q   <= bus.record_in;
            cnt_q   <= cnt_d;
        end
    end

    // A completing sample holds RECORD one more cycle so done never overlaps valid.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = start ? RECORD : IDLE;
            RECORD:  state_d = (!fire && (!bus.record_in || cnt_q == CW'(MAX_SAMPLES))) ? DONE : RECORD;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.recording_out   = state_q == RECORD;
        bus.record_done_out = state_q == DONE;
    end

    boxcar_decimator #(.DECIM(DECIM)) u_decim (
        .clk_in      (clk_in),
        .rst_in      (rst_in),
        .clear_i     (start),
        .sample_i    (bus.mic_in),
        .valid_i     (dec_valid),
        .avg_o       (bus.audio_out),
        .avg_valid_o (bus.audio_valid_out),
        .fire_o      (fire)
    );
endmodule

// File: tb/tb_audio_recorder.sv
// tb_audio_recorder: directed scenarios with hand-computed expectations for audio_recorder.
module tb_audio_recorder;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int total = 0;
    int bad = 0;
    int vcnt = 0, dcnt = 0, coinc = 0, ncyc = 0, lv = 0, ld = 0;

    always #5 clk = ~clk;

    audio_recorder_if bus();

    audio_recorder #(.DECIM(8), .MAX_SAMPLES(3)) dut (
        .clk_in (clk),
        .rst_in (rst),
        .bus    (bus)
    );

    always @(negedge clk) begin
        ncyc++;
        if (bus.audio_valid_out) begin vcnt++; lv = ncyc; end
        if (bus.record_done_out) begin dcnt++; ld = ncyc; end
        if (bus.audio_valid_out && bus.record_done_out) coinc++;
    end

    task automatic cyc(input logic r, input logic v, input logic [7:0] d);
        bus.record_in = r;
        bus.mic_valid_in = v;
        bus.mic_in = d;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        cyc(0, 0, 0);
        cyc(0, 0, 0);
        if (bus.audio_out !== 8'h00) begin bad++; $display("FAIL reset_audio got=%0h want=00", bus.audio_out); end total++;
        if (bus.audio_valid_out !== 1'b0) begin bad++; $display("FAIL reset_valid got=%0b want=0", bus.audio_valid_out); end total++;
        if (bus.record_done_out !== 1'b0) begin bad++; $display("FAIL reset_done got=%0b want=0", bus.record_done_out); end total++;
        if (bus.recording_out !== 1'b0) begin bad++; $display("FAIL reset_recording got=%0b want=0", bus.recording_out); end total++;
        rst = 1'b0;
        cyc(0, 0, 0);
    endtask

    task automatic test_basic;
        int v0 = vcnt, d0 = dcnt, c0 = coinc;
        cyc(1, 0, 0);
        if (bus.recording_out !== 1'b1) begin bad++; $display("FAIL basic_recording got=%0b want=1", bus.recording_out); end total++;
        for (int i = 0; i < 19; i++) cyc(1, 1, 8'd10);
        if (vcnt - v0 !== 2) begin bad++; $display("FAIL basic_count got=%0d want=2", vcnt - v0); end total++;
        if (bus.audio_out !== 8'd10) begin bad++; $display("FAIL basic_audio got=%0h want=0a", bus.audio_out); end total++;
        cyc(0, 0, 0);
        if (bus.record_done_out !== 1'b1) begin bad++; $display("FAIL basic_done_timing got=%0b want=1", bus.record_done_out); end total++;
        cyc(0, 0, 0);
        cyc(0, 0, 0);
        if (dcnt - d0 !== 1) begin bad++; $display("FAIL basic_done_count got=%0d want=1", dcnt - d0); end total++;
        if (vcnt - v0 !== 2) begin bad++; $display("FAIL basic_no_partial got=%0d want=2", vcnt - v0); end total++;
        if (coinc !== c0) begin bad++; $display("FAIL basic_overlap got=%0d want=%0d", coinc, c0); end total++;
        if (bus.recording_out !== 1'b0) begin bad++; $display("FAIL basic_idle got=%0b want=0", bus.recording_out); end total++;
    endtask

    task automatic test_average;
        cyc(1, 0, 0);
        for (int i = 0; i < 8; i++) cyc(1, 1, (i % 2 == 1) ? 8'h7f : 8'h80);
        if (bus.audio_valid_out !== 1'b1) begin bad++; $display("FAIL avg_alt_valid got=%0b want=1", bus.audio_valid_out); end total++;
        if (bus.audio_out !== 8'hff) begin bad++; $display("FAIL avg_alt got=%0h want=ff", bus.audio_out); end total++;
        for (int i = 0; i < 8; i++) cyc(1, 1, 8'd5);
        if (bus.audio_out !== 8'h05) begin bad++; $display("FAIL avg_five got=%0h want=05", bus.audio_out); end total++;
        for (int i = 0; i < 3; i++) cyc(0, 0, 0);
        cyc(1, 0, 0);
        for (int i = 0; i < 8; i++) cyc(1, 1, 8'hff);
        if (bus.audio_out !== 8'hff) begin bad++; $display("FAIL avg_minus1 got=%0h want=ff", bus.audio_out); end total++;
        for (int i = 0; i < 8; i++) cyc(1, 1, (i == 0) ? 8'hf7 : 8'h00);
        if (bus.audio_out !== 8'hfe) begin bad++; $display("FAIL avg_floor got=%0h want=fe", bus.audio_out); end total++;
        for (int i = 0; i < 3; i++) cyc(0, 0, 0);
    endtask

    task automatic test_max;
        int v0 = vcnt, d0 = dcnt;
        cyc(1, 0, 0);
        for (int i = 0; i < 30; i++) cyc(1, 1, 8'd3);
        if (vcnt - v0 !== 3) begin bad++; $display("FAIL max_count got=%0d want=3", vcnt - v0); end total++;
        if (dcnt - d0 !== 1) begin bad++; $display("FAIL max_done got=%0d want=1", dcnt - d0); end total++;
        if (ld !== lv + 1) begin bad++; $display("FAIL max_done_cycle got=%0d want=%0d", ld, lv + 1); end total++;
        if (bus.audio_out !== 8'd3) begin bad++; $display("FAIL max_audio got=%0h want=03", bus.audio_out); end total++;
        for (int i = 0; i < 10; i++) cyc(1, 1, 8'd3);
        if (bus.recording_out !== 1'b0) begin bad++; $display("FAIL max_no_restart got=%0b want=0", bus.recording_out); end total++;
        if (vcnt - v0 !== 3) begin bad++; $display("FAIL max_held got=%0d want=3", vcnt - v0); end total++;
        cyc(0, 0, 0);
        cyc(1, 0, 0);
        if (bus.recording_out !== 1'b1) begin bad++; $display("FAIL max_repress got=%0b want=1", bus.recording_out); end total++;
        for (int i = 0; i < 3; i++) cyc(0, 0, 0);
        if (dcnt - d0 !== 2) begin bad++; $display("FAIL max_second_done got=%0d want=2", dcnt - d0); end total++;
    endtask

    task automatic test_simultaneous;
        cyc(1, 0, 0);
        for (int i = 0; i < 7; i++) cyc(1, 1, 8'd42);
        cyc(0, 1, 8'd42);
        if (bus.audio_valid_out !== 1'b1) begin bad++; $display("FAIL simul_valid got=%0b want=1", bus.audio_valid_out); end total++;
        if (bus.audio_out !== 8'd42) begin bad++; $display("FAIL simul_audio got=%0h want=2a", bus.audio_out); end total++;
        if (bus.record_done_out !== 1'b0) begin bad++; $display("FAIL simul_early_done got=%0b want=0", bus.record_done_out); end total++;
        cyc(0, 0, 0);
        if (bus.record_done_out !== 1'b1) begin bad++; $display("FAIL simul_done got=%0b want=1", bus.record_done_out); end total++;
        if (bus.audio_valid_out !== 1'b0) begin bad++; $display("FAIL simul_valid_off got=%0b want=0", bus.audio_valid_out); end total++;
        cyc(0, 0, 0);
        if (bus.record_done_out !== 1'b0) begin bad++; $display("FAIL simul_done_once got=%0b want=0", bus.record_done_out); end total++;
    endtask

    task automatic test_reset_mid;
        int d0;
        cyc(1, 0, 0);
        for (int i = 0; i < 5; i++) cyc(1, 1, 8'd100);
        rst = 1'b1;
        cyc(1, 0, 0);
        if (bus.audio_out !== 8'h00) begin bad++; $display("FAIL midrst_audio got=%0h want=00", bus.audio_out); end total++;
        if (bus.recording_out !== 1'b0) begin bad++; $display("FAIL midrst_recording got=%0b want=0", bus.recording_out); end total++;
        if (bus.record_done_out !== 1'b0) begin bad++; $display("FAIL midrst_done got=%0b want=0", bus.record_done_out); end total++;
        rst = 1'b0;
        d0 = dcnt;
        for (int i = 0; i < 3; i++) cyc(0, 0, 0);
        if (dcnt !== d0) begin bad++; $display("FAIL midrst_no_done got=%0d want=%0d", dcnt, d0); end total++;
        cyc(1, 0, 0);
        for (int i = 0; i < 8; i++) cyc(1, 1, 8'd16);
        if (bus.audio_out !== 8'd16) begin bad++; $display("FAIL midrst_clean got=%0h want=10", bus.audio_out); end total++;
        for (int i = 0; i < 3; i++) cyc(0, 0, 0);
        if (dcnt - d0 !== 1) begin bad++; $display("FAIL midrst_next_done got=%0d want=1", dcnt - d0); end total++;
    endtask

    task automatic test_held_reset;
        int v0;
        rst = 1'b1;
        cyc(1, 0, 0);
        cyc(1, 0, 0);
        rst = 1'b0;
        v0 = vcnt;
        for (int i = 0; i < 12; i++) cyc(1, 1, 8'd50);
        if (bus.recording_out !== 1'b0) begin bad++; $display("FAIL held_no_start got=%0b want=0", bus.recording_out); end total++;
        if (vcnt !== v0) begin bad++; $display("FAIL held_idle_valid got=%0d want=%0d", vcnt, v0); end total++;
        cyc(0, 0, 0);
        cyc(1, 0, 0);
        if (bus.recording_out !== 1'b1) begin bad++; $display("FAIL held_fresh_press got=%0b want=1", bus.recording_out); end total++;
        for (int i = 0; i < 8; i++) cyc(1, 1, 8'd50);
        if (bus.audio_out !== 8'd50) begin bad++; $display("FAIL held_audio got=%0h want=32", bus.audio_out); end total++;
        for (int i = 0; i < 3; i++) cyc(0, 0, 0);
    endtask

    initial begin
        bus.record_in = 1'b0;
        bus.mic_valid_in = 1'b0;
        bus.mic_in = 8'h00;
        test_reset();
        test_basic();
        test_average();
        test_max();
        test_simultaneous();
        test_reset_mid();
        test_held_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
